// File: rtl/seqdec_byte_serializer.sv
// Byte FIFO feeding an MSB-first serializer for the seqdec_97 detector input.
// Back-to-back bytes are emitted with no gap; OutBit sits at IDLE_BIT when nothing is shifting.
module seqdec_byte_serializer #(
  parameter int   DEPTH    = 4,
  parameter logic IDLE_BIT = 1'b0,
  localparam int  CW       = $clog2(DEPTH) + 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [7:0]    InData,
  input  logic          InValid,
  output logic          InReady,
  output logic          OutBit,
  output logic          OutValid,
  output logic          Busy,
  output logic [CW-1:0] Count
);

  localparam int PW = $clog2(DEPTH);

  // States: IDLE  | shifter empty, OutBit held at IDLE_BIT
  //         SHIFT | a byte is being shifted out, OutValid high
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_next;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    bitcnt, bitcnt_next;
  logic [6:0]    shreg, shreg_next;
  logic          out_bit_next, out_valid_next;
  logic          push, pop;
  logic [7:0]    head;

  assign InReady = !Reset && (Count < CW'(DEPTH));
  assign push    = InValid && InReady;
  assign pop     = (Count != '0) && ((state == IDLE) || (bitcnt == 3'd7));
  assign head    = mem[rd_ptr];
  assign Busy    = (state == SHIFT) || (Count != '0);

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= InData;
  end

  always_comb begin
    state_next     = state;
    bitcnt_next    = bitcnt;
    shreg_next     = shreg;
    out_bit_next   = OutBit;
    out_valid_next = OutValid;
    case (state)
      IDLE: begin
        if (pop) begin
          state_next     = SHIFT;
          out_bit_next   = head[7];
          out_valid_next = 1'b1;
          shreg_next     = head[6:0];
          bitcnt_next    = 3'd0;
        end
      end
      SHIFT: begin
        if (bitcnt != 3'd7) begin
          out_bit_next = shreg[6];
          shreg_next   = {shreg[5:0], 1'b0};
          bitcnt_next  = bitcnt + 3'd1;
        end else if (pop) begin
          // next byte loads on the same edge its predecessor's bit 0 retires
          out_bit_next   = head[7];
          out_valid_next = 1'b1;
          shreg_next     = head[6:0];
          bitcnt_next    = 3'd0;
        end else begin
          state_next     = IDLE;
          out_bit_next   = IDLE_BIT;
          out_valid_next = 1'b0;
        end
      end
      default: begin
        state_next     = IDLE;
        out_bit_next   = IDLE_BIT;
        out_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      bitcnt   <= 3'd0;
      shreg    <= 7'd0;
      OutBit   <= IDLE_BIT;
      OutValid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
    end else begin
      state    <= state_next;
      bitcnt   <= bitcnt_next;
      shreg    <= shreg_next;
      OutBit   <= out_bit_next;
      OutValid <= out_valid_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: Count <= Count;
      endcase
    end
  end

endmodule

// File: tb/tb_seqdec_byte_serializer.sv
// Randomized and directed bench for seqdec_byte_serializer, checked every cycle
// against a queue-based model of the FIFO and the outgoing bit stream.
module tb_seqdec_byte_serializer;

  localparam int   DEPTH    = 4;
  localparam logic IDLE_BIT = 1'b0;
  localparam int   CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          out_bit;
  logic          out_valid;
  logic          busy;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;
  bit started = 0;
  bit saw_full = 0;
  bit saw_ready_drop = 0;

  logic [7:0] m_fifo[$];
  logic       m_stream[$];
  logic       cap[$];

  seqdec_byte_serializer #(.DEPTH(DEPTH), .IDLE_BIT(IDLE_BIT)) dut (
    .Clk(clk), .Reset(reset), .InData(in_data), .InValid(in_valid),
    .InReady(in_ready), .OutBit(out_bit), .OutValid(out_valid),
    .Busy(busy), .Count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes waiting in the FIFO, and the bits still to appear on OutBit
  // (front element is the bit currently on the wire).
  always @(posedge clk) begin
    if (reset) begin
      m_fifo.delete();
      m_stream.delete();
    end else begin
      automatic bit do_push = in_valid && (m_fifo.size() < DEPTH);
      automatic logic [7:0] b;
      if (m_stream.size() > 0) void'(m_stream.pop_front());
      if (m_stream.size() == 0 && m_fifo.size() > 0) begin
        b = m_fifo.pop_front();
        for (int i = 7; i >= 0; i--) m_stream.push_back(b[i]);
      end
      if (do_push) m_fifo.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      automatic bit   e_valid = (m_stream.size() != 0);
      automatic logic e_bit   = e_valid ? m_stream[0] : IDLE_BIT;
      chk("out_valid", out_valid, e_valid);
      chk("out_bit",   out_bit,   e_bit);
      chk("busy",      busy,      e_valid || (m_fifo.size() != 0));
      chk("count",     count,     m_fifo.size());
      chk("in_ready",  in_ready,  !reset && (m_fifo.size() < DEPTH));
      if (out_valid) cap.push_back(out_bit);
      if (count == CW'(DEPTH)) saw_full = 1;
      if (count == CW'(DEPTH) && !in_ready) saw_ready_drop = 1;
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    in_valid = v;
    in_data  = d;
    reset    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    cyc(0, 8'h00, 0);
    while (busy && n < 300) begin
      cyc(0, 8'h00, 0);
      n++;
    end
    cyc(0, 8'h00, 0);
    chk("drain_done", busy, 0);
  endtask

  task automatic push_wait(input logic [7:0] d);
    int n = 0;
    while (!in_ready && n < 100) begin
      cyc(0, 8'h00, 0);
      n++;
    end
    chk("push_wait_ready", in_ready, 1);
    cyc(1, d, 0);
  endtask

  function automatic logic [7:0] cap_byte(input int k);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = cap[8*k + i];
    return b;
  endfunction

  initial begin
    logic [7:0] exp_bytes[$];
    in_valid = 0; in_data = 0; reset = 1;
    cyc(0, 8'h00, 1);
    started = 1;
    cyc(0, 8'h00, 1);

    // idle after reset
    for (int i = 0; i < 20; i++) begin
      cyc(0, 8'h00, 0);
      chk("t6_out_bit", out_bit, IDLE_BIT);
      chk("t6_out_valid", out_valid, 0);
      chk("t6_in_ready", in_ready, 1);
      chk("t6_count", count, 0);
    end

    // single byte 0x97
    cap.delete();
    cyc(1, 8'h97, 0);
    chk("t1_latency_pre", out_valid, 0);
    cyc(0, 8'h00, 0);
    chk("t1_first_bit", out_bit, 1);
    drain();
    chk("t1_nbits", cap.size(), 8);
    if (cap.size() == 8) chk("t1_byte", cap_byte(0), 8'h97);
    chk("t1_busy_after", busy, 0);
    chk("t1_idle_bit", out_bit, IDLE_BIT);

    // two bytes back-to-back
    cap.delete();
    cyc(1, 8'h85, 0);
    cyc(1, 8'h97, 0);
    drain();
    chk("t2_nbits", cap.size(), 16);
    if (cap.size() == 16) chk("t2_stream", {cap_byte(0), cap_byte(1)}, 16'h8597);

    // hold valid while shifting until FIFO fills
    begin
      int i = 0;
      int n = 0;
      cap.delete();
      saw_full = 0; saw_ready_drop = 0;
      while (i < 6 && n < 200) begin
        automatic logic r = in_ready;
        cyc(1, 8'h11 + 8'(i), 0);
        if (r) i++;
        n++;
      end
      chk("t3_all_accepted", i, 6);
      drain();
      chk("t3_full_seen", saw_full, 1);
      chk("t3_ready_drop", saw_ready_drop, 1);
      chk("t3_nbits", cap.size(), 48);
      if (cap.size() == 48)
        for (int k = 0; k < 6; k++) chk("t3_order", cap_byte(k), 8'h11 + k);
    end

    // push coinciding with internal pop at count 2
    cap.delete();
    cyc(1, 8'hA1, 0);
    cyc(1, 8'hB2, 0);
    cyc(1, 8'hC3, 0);
    repeat (6) cyc(0, 8'h00, 0);
    chk("t4_count_before", count, 2);
    cyc(1, 8'hD4, 0);
    chk("t4_count_same", count, 2);
    chk("t4_next_msb", out_bit, 1);
    drain();
    chk("t4_nbits", cap.size(), 32);
    if (cap.size() == 32) chk("t4_order", {cap_byte(0), cap_byte(1), cap_byte(2), cap_byte(3)}, 32'hA1B2C3D4);

    // ten sequential bytes wrap the pointers
    cap.delete();
    exp_bytes.delete();
    for (int k = 0; k < 10; k++) begin
      automatic logic [7:0] d = 8'($urandom);
      exp_bytes.push_back(d);
      push_wait(d);
    end
    drain();
    chk("wrap_nbits", cap.size(), 80);
    if (cap.size() == 80)
      for (int k = 0; k < 10; k++) chk("wrap_order", cap_byte(k), exp_bytes[k]);

    // randomized traffic with occasional reset
    for (int k = 0; k < 600; k++)
      cyc($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 63) == 0);
    drain();

    // reset mid-byte with two bytes queued
    cap.delete();
    cyc(1, 8'h53, 0);
    cyc(1, 8'h21, 0);
    cyc(1, 8'h22, 0);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
    chk("t5_count_queued", count, 2);
    chk("t5_bit4", out_bit, 1);
    cyc(1, 8'h44, 1);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_bit", out_bit, IDLE_BIT);
    chk("t5_count", count, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready_in_reset", in_ready, 0);
    cap.delete();
    cyc(1, 8'h3C, 0);
    drain();
    chk("t5_nbits", cap.size(), 8);
    if (cap.size() == 8) chk("t5_byte", cap_byte(0), 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
